// File: rtl/lamp_sqrt_ctrl.sv
// Issue/pack controller in front of the square-root core: handles special operands
// locally, issues normal ones to the core and repacks its fixed-point result.
module lamp_sqrt_ctrl #(
    parameter int E_DW = 8,
    parameter int F_DW = 7,
    parameter int BIAS = 127
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     doOp_i,
    input  logic [E_DW+F_DW:0]       op_i,
    input  logic                     invSqrt_i,
    output logic                     busy_o,
    output logic                     doSqrt_o,
    output logic [F_DW:0]            s_o,
    output logic                     is_exp_odd_o,
    output logic                     invSqrt_o,
    input  logic [2*(F_DW+1)-1:0]    core_res_i,
    input  logic                     core_valid_i,
    output logic [E_DW+F_DW:0]       res_o,
    output logic                     valid_o,
    output logic                     invalid_o,
    output logic                     divByZero_o
);
    localparam int W  = 1 + E_DW + F_DW;
    localparam int RW = 2 * (F_DW + 1);
    localparam logic signed [E_DW+1:0] BIAS_X = (E_DW+2)'(BIAS);
    localparam logic [W-1:0] POS_INF = {1'b0, {E_DW{1'b1}}, {F_DW{1'b0}}};
    localparam logic [W-1:0] QNAN    = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state;

    logic                   op_sign, is_zero, exp_max, frac_nz, special;
    logic [E_DW-1:0]        op_exp;
    logic [F_DW-1:0]        op_frac;
    logic signed [E_DW:0]   op_e, e_q;
    logic [W-1:0]           spec_res;
    logic                   spec_inv, spec_dbz;

    always_comb begin
        op_sign  = op_i[W-1];
        op_exp   = op_i[W-2:F_DW];
        op_frac  = op_i[F_DW-1:0];
        is_zero  = (op_exp == '0);
        exp_max  = &op_exp;
        frac_nz  = |op_frac;
        special  = is_zero | exp_max | op_sign;
        op_e     = $signed({1'b0, op_exp}) - $signed((E_DW+1)'(BIAS));
        spec_res = '0;
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        // zero is tested first so -0 is not treated as a negative operand
        if (is_zero) begin
            spec_res = invSqrt_i ? POS_INF : {op_sign, {(W-1){1'b0}}};
            spec_dbz = invSqrt_i;
        end else if ((exp_max && frac_nz) || op_sign) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else begin
            spec_res = invSqrt_i ? '0 : POS_INF;
        end
    end

    logic [RW-1:0]          norm;
    logic [F_DW-1:0]        frac_t;
    logic                   guard, sticky, rnd_up;
    logic [F_DW:0]          frac_r;
    logic signed [E_DW+1:0] ex, hx, adj_x, cy_x, exp_s;
    logic [W-1:0]           pack_res;

    always_comb begin
        norm   = core_res_i[RW-1] ? core_res_i : (core_res_i << 1);
        frac_t = norm[RW-2 -: F_DW];
        guard  = norm[RW-2-F_DW];
        sticky = |norm[RW-3-F_DW:0];
        rnd_up = guard & (sticky | frac_t[0]);
        frac_r = {1'b0, frac_t} + {{F_DW{1'b0}}, rnd_up};
        ex     = {e_q[E_DW], e_q};
        hx     = ex >>> 1;
        adj_x  = core_res_i[RW-1] ? '0 : '1;
        cy_x   = {{(E_DW+1){1'b0}}, frac_r[F_DW]};
        exp_s  = BIAS_X + (invSqrt_o ? -hx : hx) + adj_x + cy_x;
        pack_res = {1'b0, exp_s[E_DW-1:0], frac_r[F_DW-1:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            doSqrt_o     <= 1'b0;
            s_o          <= '0;
            is_exp_odd_o <= 1'b0;
            invSqrt_o    <= 1'b0;
            e_q          <= '0;
            res_o        <= '0;
            valid_o      <= 1'b0;
            invalid_o    <= 1'b0;
            divByZero_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (doOp_i) begin
                        invSqrt_o <= invSqrt_i;
                        if (special) begin
                            res_o       <= spec_res;
                            invalid_o   <= spec_inv;
                            divByZero_o <= spec_dbz;
                            valid_o     <= 1'b1;
                            state       <= DONE;
                        end else begin
                            s_o          <= {1'b1, op_frac};
                            e_q          <= op_e;
                            is_exp_odd_o <= op_e[0];
                            doSqrt_o     <= 1'b1;
                            busy_o       <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    state <= WAIT;
                    if (core_valid_i) begin
                        doSqrt_o    <= 1'b0;
                        busy_o      <= 1'b0;
                        res_o       <= pack_res;
                        invalid_o   <= 1'b0;
                        divByZero_o <= 1'b0;
                        valid_o     <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lamp_sqrt_ctrl.sv
// Bench for lamp_sqrt_ctrl: behavioural sqrt core, vector table, scoreboard of
// expected packed results, plus busy-drop and mid-operation reset sequences.
module tb_lamp_sqrt_ctrl;
    logic        clk_tb, rst_n;
    logic        doOp_i, invSqrt_i;
    logic [15:0] op_i;
    logic        busy_o, doSqrt_o, is_exp_odd_o, invSqrt_o;
    logic [7:0]  s_o;
    logic [15:0] core_res_i;
    logic        core_valid_i;
    logic [15:0] res_o;
    logic        valid_o, invalid_o, divByZero_o;

    lamp_sqrt_ctrl #(.E_DW(8), .F_DW(7), .BIAS(127)) dut (
        .clk(clk_tb), .rst(rst_n), .doOp_i(doOp_i), .op_i(op_i), .invSqrt_i(invSqrt_i),
        .busy_o(busy_o), .doSqrt_o(doSqrt_o), .s_o(s_o), .is_exp_odd_o(is_exp_odd_o),
        .invSqrt_o(invSqrt_o), .core_res_i(core_res_i), .core_valid_i(core_valid_i),
        .res_o(res_o), .valid_o(valid_o), .invalid_o(invalid_o), .divByZero_o(divByZero_o)
    );

    initial begin
        clk_tb = 1'b0;
        forever #5 clk_tb = ~clk_tb;
    end

    typedef struct {
        logic [15:0] op;
        logic        inv;
        logic [15:0] res;
        logic        invalid;
        logic        dbz;
        logic        special;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        invalid;
        logic        dbz;
    } sb_t;

    sb_t sbq[$];
    int  compared = 0;
    int  mismatched = 0;
    int  valid_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] core_val(input logic [7:0] s, input logic odd, input logic inv);
        real m, r;
        m = (real'(s) / 128.0) * (odd ? 2.0 : 1.0);
        r = inv ? 1.0 / $sqrt(m) : $sqrt(m);
        return 16'($rtoi(r * 32768.0 + 0.5));
    endfunction

    // Reference result: core value scaled by 2^(+-floor(e/2)), renormalised and
    // rounded to nearest-even in real arithmetic.
    function automatic logic [15:0] pack_model(input logic [15:0] op, input logic inv);
        int  e, h, ee, fi;
        real v, f;
        logic odd;
        e   = int'(op[14:7]) - 127;
        h   = $rtoi($floor(real'(e) / 2.0));
        odd = (e % 2) != 0;
        v   = real'(core_val({1'b1, op[6:0]}, odd, inv)) / 32768.0;
        ee  = inv ? -h : h;
        while (v >= 2.0) begin v = v / 2.0; ee++; end
        while (v < 1.0)  begin v = v * 2.0; ee--; end
        f  = (v - 1.0) * 128.0;
        fi = $rtoi($floor(f));
        if ((f - real'(fi) > 0.5) || ((f - real'(fi) == 0.5) && (fi % 2 == 1))) fi++;
        if (fi == 128) begin fi = 0; ee++; end
        return {1'b0, 8'(ee + 127), 7'(fi)};
    endfunction

    // Behavioural core: latches the request, answers after 3..10 cycles and holds
    // valid until the controller drops doSqrt_o.
    initial begin
        int lat, k, n;
        logic [15:0] cv;
        core_valid_i = 1'b0;
        core_res_i   = '0;
        forever begin
            @(posedge clk_tb); #1;
            if (doSqrt_o) begin
                lat = $urandom_range(3, 10);
                cv  = core_val(s_o, is_exp_odd_o, invSqrt_o);
                k   = 1;
                while (k < lat && doSqrt_o) begin @(posedge clk_tb); #1; k++; end
                if (doSqrt_o) begin
                    core_res_i   = cv;
                    core_valid_i = 1'b1;
                    n = 0;
                    while (doSqrt_o && n < 50) begin @(posedge clk_tb); #1; n++; end
                    core_valid_i = 1'b0;
                end
            end
        end
    end

    always @(negedge clk_tb) begin
        if (rst_n && valid_o) begin
            sb_t e;
            valid_cnt++;
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_valid: res 0x%0h with no pending op", res_o);
            end else begin
                e = sbq.pop_front();
                chk("res", res_o, e.res);
                chk("invalid", invalid_o, e.invalid);
                chk("dbz", divByZero_o, e.dbz);
            end
        end
    end

    task automatic start(input logic [15:0] op, input logic inv);
        doOp_i    = 1'b1;
        op_i      = op;
        invSqrt_i = inv;
        @(posedge clk_tb); #1;
        doOp_i    = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        logic held = 1'b1;
        while (!valid_o && n < 60) begin
            if (!doSqrt_o) held = 1'b0;
            @(posedge clk_tb); #1;
            n++;
        end
        chk({name, "_valid"}, valid_o, 1'b1);
        chk({name, "_dosqrt_held"}, held, 1'b1);
        chk({name, "_dosqrt_drop"}, doSqrt_o, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        logic odd;
        sbq.push_back('{res: v.res, invalid: v.invalid, dbz: v.dbz});
        start(v.op, v.inv);
        if (v.special) begin
            chk("spec_latency", valid_o, 1'b1);
            chk("spec_no_dosqrt", doSqrt_o, 1'b0);
        end else begin
            odd = ((int'(v.op[14:7]) - 127) % 2) != 0;
            chk("s_o", s_o, {1'b1, v.op[6:0]});
            chk("exp_odd", is_exp_odd_o, odd);
            chk("inv_o", invSqrt_o, v.inv);
            chk("busy", busy_o, 1'b1);
            wait_valid("norm");
            chk("busy_at_valid", busy_o, 1'b0);
        end
        @(posedge clk_tb); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1);
    end

    initial begin
        vec_t tbl[12];
        vec_t rv;
        int   vc;
        tbl[0]  = '{16'h4080, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{16'h4000, 1'b0, 16'h3FB5, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{16'h4080, 1'b1, 16'h3F00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{16'h3E80, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{16'h4000, 1'b1, 16'h3F35, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{16'hBF80, 1'b0, 16'h7FC0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{16'h0000, 1'b1, 16'h7F80, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{16'h7F80, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{16'h7F80, 1'b0, 16'h7F80, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{16'h7FC1, 1'b0, 16'h7FC0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{16'hFF80, 1'b1, 16'h7FC0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; doOp_i = 1'b0; op_i = '0; invSqrt_i = 1'b0;
        #3;
        chk("reset_outputs",
            {busy_o, doSqrt_o, s_o, is_exp_odd_o, invSqrt_o, res_o, valid_o, invalid_o, divByZero_o}, '0);
        #19 rst_n = 1'b1;
        @(posedge clk_tb); #1;

        foreach (tbl[i]) run_vec(tbl[i]);

        for (int i = 0; i < 12; i++) begin
            rv.op      = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
            rv.inv     = 1'($urandom);
            rv.res     = pack_model(rv.op, rv.inv);
            rv.invalid = 1'b0;
            rv.dbz     = 1'b0;
            rv.special = 1'b0;
            run_vec(rv);
        end

        // doOp during WAIT is dropped; a new op is taken on the edge after valid_o
        vc = valid_cnt;
        sbq.push_back('{res: 16'h4000, invalid: 1'b0, dbz: 1'b0});
        start(16'h4080, 1'b0);
        @(posedge clk_tb); #1;
        doOp_i = 1'b1; op_i = 16'h4000; invSqrt_i = 1'b0;
        @(posedge clk_tb); #1;
        doOp_i = 1'b0;
        wait_valid("busy_drop");
        sbq.push_back('{res: 16'h7FC0, invalid: 1'b1, dbz: 1'b0});
        start(16'hBF80, 1'b0);
        chk("accept_after_valid", valid_o, 1'b1);
        repeat (15) @(posedge clk_tb);
        #1;
        chk("busy_drop_valids", valid_cnt - vc, 2);

        // reset during WAIT aborts without a clock edge and yields no result
        vc = valid_cnt;
        start(16'h4080, 1'b0);
        @(posedge clk_tb); #1;
        chk("pre_reset_dosqrt", doSqrt_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outs", {doSqrt_o, busy_o, valid_o}, 3'b000);
        repeat (2) @(posedge clk_tb);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk_tb);
        #1;
        chk("no_valid_after_reset", valid_cnt - vc, 0);
        run_vec(tbl[1]);

        repeat (5) @(posedge clk_tb);
        #1;
        chk("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
